// File: rtl/adc_capture_controller.sv
// Ping-pong capture controller: decimates the XADC stream, waits for a rising
// level crossing (or an auto-trigger timeout), writes one record into the BRAM
// the renderer is not reading, and swaps buffers only at a frame boundary.
module adc_capture_controller #(
  parameter int DEPTH       = 1280,
  parameter int ADDR_W      = 12,
  parameter int AUTO_FRAMES = 8
) (
  input  logic              CLK104MHZ,
  input  logic              RST,
  input  logic              ADC_VALID,
  input  logic [11:0]       ADC_OUT,
  input  logic [7:0]        DECIM,
  input  logic              TRIG_EN,
  input  logic [11:0]       TRIG_LEVEL,
  input  logic              FRAME_START,
  output logic              WR_EN,
  output logic              WR_SEL,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [11:0]       WR_DATA,
  output logic              activeBRAMselect,
  output logic              CAPTURE_DONE
);

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam int FCW = (AUTO_FRAMES < 1) ? 1 : $clog2(AUTO_FRAMES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [FCW-1:0]    AUTO_LIMIT = FCW'(AUTO_FRAMES);

  logic [1:0]        state_q, state_d;
  logic              entry_q, entry_d;
  logic [7:0]        decim_q, decim_d;
  logic [11:0]       level_q, level_d;
  logic [7:0]        dec_cnt_q, dec_cnt_d;
  logic [11:0]       prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic              auto_armed_q, auto_armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              sel_q, sel_d;
  logic              wr_sel_q, wr_sel_d;
  logic              done_q, done_d;

  logic [7:0]        decim_eff;
  logic [11:0]       level_eff;
  logic              accept;
  logic              crossing;

  // Reset enters ARM without a clock edge to latch DECIM/TRIG_LEVEL, so the
  // first cycle after reset uses the live inputs and latches them.
  always_comb begin
    decim_eff = entry_q ? DECIM : decim_q;
    level_eff = entry_q ? TRIG_LEVEL : level_q;
    accept    = ADC_VALID && (dec_cnt_q == 8'd0);
    crossing  = prev_valid_q && ($signed(prev_q) < $signed(level_eff)) &&
                ($signed(ADC_OUT) >= $signed(level_eff));
  end

  // Next-state logic: decimator, trigger search, record write and buffer swap.
  always_comb begin
    state_d      = state_q;
    entry_d      = 1'b0;
    decim_d      = decim_eff;
    level_d      = level_eff;
    dec_cnt_d    = dec_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    frame_cnt_d  = frame_cnt_q;
    auto_armed_d = auto_armed_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sel_d        = sel_q;
    wr_sel_d     = wr_sel_q;
    done_d       = 1'b0;

    if (ADC_VALID) begin
      dec_cnt_d = accept ? decim_eff : dec_cnt_q - 8'd1;
    end

    case (state_q)
      ST_ARM: begin
        if (accept && (!TRIG_EN || crossing || auto_armed_q)) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = ADC_OUT;
          addr_d       = ADDR_W'(1);
          state_d      = (DEPTH == 1) ? ST_FULL : ST_CAPTURE;
          prev_valid_d = 1'b0;
          frame_cnt_d  = '0;
          auto_armed_d = 1'b0;
        end else begin
          if (accept) begin
            prev_d       = ADC_OUT;
            prev_valid_d = 1'b1;
          end
          if (FRAME_START && (AUTO_FRAMES != 0) && !auto_armed_q) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_q + 1'b1 == AUTO_LIMIT) begin
              auto_armed_d = 1'b1;
            end
          end
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = ADC_OUT;
          addr_d    = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (FRAME_START) begin
          sel_d        = ~sel_q;
          wr_sel_d     = sel_q;
          done_d       = 1'b1;
          state_d      = ST_ARM;
          decim_d      = DECIM;
          level_d      = TRIG_LEVEL;
          dec_cnt_d    = '0;
          prev_valid_d = 1'b0;
          frame_cnt_d  = '0;
          auto_armed_d = 1'b0;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // State and registered outputs, asynchronously reset.
  always_ff @(posedge CLK104MHZ or posedge RST) begin
    if (RST) begin
      state_q      <= ST_ARM;
      entry_q      <= 1'b1;
      decim_q      <= '0;
      level_q      <= '0;
      dec_cnt_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      auto_armed_q <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sel_q        <= 1'b0;
      wr_sel_q     <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      decim_q      <= decim_d;
      level_q      <= level_d;
      dec_cnt_q    <= dec_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      auto_armed_q <= auto_armed_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sel_q        <= sel_d;
      wr_sel_q     <= wr_sel_d;
      done_q       <= done_d;
    end
  end

  assign WR_EN            = wr_en_q;
  assign WR_SEL           = wr_sel_q;
  assign WR_ADDR          = wr_addr_q;
  assign WR_DATA          = wr_data_q;
  assign activeBRAMselect = sel_q;
  assign CAPTURE_DONE     = done_q;

endmodule

// File: tb/tb_adc_capture_controller.sv
// Bench for adc_capture_controller: sample-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_adc_capture_controller;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam int AUTO   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              adc_valid = 1'b0;
  logic [11:0]       adc_out = '0;
  logic [7:0]        decim = '0;
  logic              trig_en = 1'b1;
  logic [11:0]       trig_level = '0;
  logic              frame_start = 1'b0;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              active_sel;
  logic              capture_done;

  adc_capture_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AUTO_FRAMES(AUTO)) dut (
    .CLK104MHZ(clk), .RST(rst), .ADC_VALID(adc_valid), .ADC_OUT(adc_out),
    .DECIM(decim), .TRIG_EN(trig_en), .TRIG_LEVEL(trig_level),
    .FRAME_START(frame_start), .WR_EN(wr_en), .WR_SEL(wr_sel),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .activeBRAMselect(active_sel),
    .CAPTURE_DONE(capture_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int sx(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  // Reference model: mode 0 = waiting for trigger, 1 = recording, 2 = record full.
  int m_mode, m_vcnt, m_decim, m_level, m_prev, m_have_prev, m_frames, m_n, m_sel;
  bit m_fresh;
  bit e_en, e_done;
  int e_addr, e_data;

  task automatic model_reset();
    m_mode = 0; m_vcnt = 0; m_have_prev = 0; m_frames = 0; m_n = 0; m_sel = 0;
    m_decim = 0; m_level = 0; m_prev = 0; m_fresh = 1'b1;
    e_en = 1'b0; e_done = 1'b0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit fs,
                            input int dec_in, input int lvl_in, input bit ten);
    bit acc;
    bit auto_go;
    if (m_fresh) begin
      m_decim = dec_in; m_level = lvl_in; m_fresh = 1'b0;
    end
    e_en = 1'b0; e_done = 1'b0;
    acc = v && ((m_vcnt % (m_decim + 1)) == 0);
    if (v) m_vcnt++;
    case (m_mode)
      0: begin
        auto_go = (AUTO > 0) && (m_frames >= AUTO);
        if (acc && (!ten || (m_have_prev != 0 && m_prev < m_level && s >= m_level) || auto_go)) begin
          e_en = 1'b1; e_addr = 0; e_data = s; m_n = 1;
          m_mode = (DEPTH == 1) ? 2 : 1;
        end else begin
          if (acc) begin m_prev = s; m_have_prev = 1; end
          if (fs) m_frames++;
        end
      end
      1: begin
        if (acc) begin
          e_en = 1'b1; e_addr = m_n; e_data = s; m_n++;
          if (m_n == DEPTH) m_mode = 2;
        end
      end
      default: begin
        if (fs) begin
          m_sel ^= 1; e_done = 1'b1; m_mode = 0; m_vcnt = 0; m_have_prev = 0;
          m_frames = 0; m_decim = dec_in; m_level = lvl_in;
        end
      end
    endcase
  endtask

  typedef struct { int cyc; int addr; int data; int sel; } wr_t;
  wr_t wlog[$];
  int  cyc_n = 0;

  // Model advance on each rising edge; compare and log writes on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(adc_valid, sx(adc_out), frame_start, int'(decim), sx(trig_level), trig_en);
      @(negedge clk);
      cyc_n++;
      if (!rst) begin
        chk("wr_en", int'(wr_en), int'(e_en));
        if (e_en) begin
          chk("wr_addr", int'(wr_addr), e_addr);
          chk("wr_data", sx(wr_data), e_data);
        end
        chk("active_sel", int'(active_sel), m_sel);
        chk("wr_sel", int'(wr_sel), 1 - m_sel);
        chk("capture_done", int'(capture_done), int'(e_done));
        if (wr_en) wlog.push_back('{cyc_n, int'(wr_addr), sx(wr_data), int'(wr_sel)});
      end
    end
  end

  // One clock of stimulus: inputs held for exactly one rising edge.
  task automatic cyc(input bit v, input int d, input bit fs);
    adc_valid = v; adc_out = 12'(d); frame_start = fs;
    @(posedge clk); #2;
    adc_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"}, int'(active_sel), 0);
    chk({tag, "_wr_sel"}, int'(wr_sel), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_done"}, int'(capture_done), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard_vals[11] = '{20, 30, 5, 15, 16, 17, 18, 19, 20, 21, 22};
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Edge trigger on a -5..+10 ramp, level 0.
    wlog.delete();
    for (int v = -5; v <= 10; v++) cyc(1'b1, v, 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("edge_count", wlog.size(), DEPTH);
    for (int k = 0; k < wlog.size() && k < DEPTH; k++) begin
      chk("edge_addr", wlog[k].addr, k);
      chk("edge_data", wlog[k].data, k);
      chk("edge_bram1", wlog[k].sel, 1);
    end

    // Swap 100 cycles after completion; next record decimated by 4.
    decim = 8'd3; trig_en = 1'b0;
    repeat (100) cyc(1'b0, 0, 1'b0);
    chk("pre_swap_sel", int'(active_sel), 0);
    cyc(1'b0, 0, 1'b1);
    chk("swap1_done", int'(capture_done), 1);
    chk("swap1_sel", int'(active_sel), 1);
    chk("swap1_wr_sel", int'(wr_sel), 0);
    decim = 8'd7;
    wlog.delete();
    cyc(1'b1, 0, 1'b0);
    chk("swap1_done_pulse", int'(capture_done), 0);
    for (int i = 1; i <= 40; i++) cyc(1'b1, i, 1'b0);
    chk("decim_count", wlog.size(), DEPTH);
    for (int k = 0; k < wlog.size() && k < DEPTH; k++) begin
      chk("decim_data", wlog[k].data, 4 * k);
      chk("decim_addr", wlog[k].addr, k);
      chk("decim_bram0", wlog[k].sel, 0);
      if (k > 0) chk("decim_spacing", wlog[k].cyc - wlog[k-1].cyc, 4);
    end

    // FRAME_START coincident with the final write does not swap.
    decim = 8'd0;
    cyc(1'b0, 0, 1'b1);
    chk("swap2_done", int'(capture_done), 1);
    wlog.delete();
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 100 + i, 1'b0);
    cyc(1'b1, 107, 1'b1);
    chk("coinc_done", int'(capture_done), 0);
    cyc(1'b0, 0, 1'b0);
    chk("coinc_done_after", int'(capture_done), 0);
    chk("coinc_sel_kept", int'(active_sel), 0);
    chk("coinc_count", wlog.size(), DEPTH);
    trig_en = 1'b1; trig_level = 12'd0;
    repeat (3) cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b1);
    chk("swap3_done", int'(capture_done), 1);
    chk("swap3_sel", int'(active_sel), 1);

    // Auto-trigger on a constant -100 below the level.
    wlog.delete();
    for (int p = 1; p <= AUTO; p++) begin
      repeat (4) cyc(1'b1, -100, 1'b0);
      cyc(1'b1, -100, 1'b1);
      if (p == AUTO - 1) chk("auto_none_after_7", wlog.size(), 0);
    end
    cyc(1'b1, -100, 1'b0);
    chk("auto_none_at_8", wlog.size(), 0);
    repeat (10) cyc(1'b1, -100, 1'b0);
    chk("auto_count", wlog.size(), DEPTH);
    if (wlog.size() > 0) begin
      chk("auto_first_addr", wlog[0].addr, 0);
      chk("auto_first_data", wlog[0].data, -100);
      chk("auto_bram0", wlog[0].sel, 0);
    end

    // First-sample guard: a first sample above the level must not trigger.
    trig_level = 12'd10;
    cyc(1'b0, 0, 1'b1);
    chk("swap4_done", int'(capture_done), 1);
    wlog.delete();
    foreach (guard_vals[i]) cyc(1'b1, guard_vals[i], 1'b0);
    cyc(1'b0, 0, 1'b0);
    chk("guard_count", wlog.size(), DEPTH);
    if (wlog.size() > 0) begin
      chk("guard_first_data", wlog[0].data, 15);
      chk("guard_first_addr", wlog[0].addr, 0);
    end

    // Asynchronous reset in the middle of a record.
    trig_en = 1'b0;
    cyc(1'b0, 0, 1'b1);
    chk("swap5_sel", int'(active_sel), 1);
    wlog.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 50 + i, 1'b0);
    chk("pre_rst_wr_en", int'(wr_en), 1);
    rst = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk);
    #2 rst = 1'b0;
    wlog.delete();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 77 + i, 1'b0);
    chk("post_rst_count", wlog.size(), DEPTH);
    if (wlog.size() > 0) begin
      chk("post_rst_addr", wlog[0].addr, 0);
      chk("post_rst_data", wlog[0].data, 77);
      chk("post_rst_bram1", wlog[0].sel, 1);
    end

    repeat (3) cyc(1'b0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
